qspi_engine: RTL and testbench

QSPI_ENGINE -- requirements
Module: qspi_engine

---
 rtl/qspi_engine.sv | 181 ++++++++++++++++++
 tb/tb_qspi_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_engine.sv
// Quad-SPI flash transaction engine: opcode, address, dummy and data phases
// in x1 or x4 mode, with one chip select per flash bank.
module qspi_engine #(
   parameter int CLK_DIV = 2,
   parameter int NB      = 2
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic [31:0]   qspi_cmd,
   input  logic [31:0]   qspi_bankmap,
   input  logic [31:0]   qspi_addr,
   input  logic [63:0]   qspi_wdata,
   input  logic          qspi_start,
   output logic [63:0]   qspi_rdata,
   output logic          qspi_idle,
   output logic          spi_sck,
   output logic [NB-1:0] spi_cs_n,
   output logic [3:0]    dq_o,
   output logic [3:0]    dq_oe,
   input  logic [3:0]    dq_i
);
   typedef enum logic [2:0] {
      S_IDLE, S_CS_SETUP, S_OPCODE, S_ADDR, S_DUMMY, S_DATA, S_CS_HOLD, S_CS_GAP
   } state_t;

   localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

   state_t      state, nxt;
   logic [7:0]  div_cnt;
   logic [6:0]  bit_cnt;
   logic [63:0] sr;
   logic [7:0]  opcode;
   logic [2:0]  n_addr;
   logic [3:0]  n_dummy, n_data;
   logic        is_write, is_quad;
   logic [31:0] addr_r;
   logic [63:0] wdata_r;

   logic [2:0]  cmd_na;
   logic [3:0]  cmd_nb;
   logic        tick, wide, ld_wide;
   logic [63:0] sr_sh, ld_sr;
   logic [6:0]  ld_cnt;
   logic [3:0]  ld_oe, ld_o, sh_o;
   logic        unused_ok;

   assign cmd_na    = (qspi_cmd[10:8] > 3'd4)  ? 3'd4 : qspi_cmd[10:8];
   assign cmd_nb    = (qspi_cmd[18:15] > 4'd8) ? 4'd8 : qspi_cmd[18:15];
   assign unused_ok = ^{qspi_cmd[31:21], qspi_bankmap};

   assign tick  = (div_cnt == 8'd0);
   assign wide  = is_quad && (state != S_OPCODE);
   assign sr_sh = wide ? {sr[59:0], 4'd0} : {sr[62:0], 1'b0};
   assign sh_o  = wide ? sr_sh[63:60] : {3'b000, sr_sh[63]};

   // Phase that follows the current one, skipping empty phases.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      nxt = S_CS_HOLD;
      case (state)
         S_CS_SETUP: nxt = S_OPCODE;
         S_OPCODE: begin
            if (n_addr != 3'd0)       nxt = S_ADDR;
            else if (n_dummy != 4'd0) nxt = S_DUMMY;
            else if (n_data != 4'd0)  nxt = S_DATA;
         end
         S_ADDR: begin
            if (n_dummy != 4'd0)      nxt = S_DUMMY;
            else if (n_data != 4'd0)  nxt = S_DATA;
         end
         S_DUMMY: if (n_data != 4'd0) nxt = S_DATA;
         default: ;
      endcase
   end

   // Shift-register image, SCK count and lane enables loaded on entry to nxt.
   always_comb begin
      ld_sr  = '0;
      ld_cnt = '0;
      ld_oe  = '0;
      case (nxt)
         S_OPCODE: begin
            ld_sr  = {opcode, 56'd0};
            ld_cnt = 7'd8;
            ld_oe  = 4'b0001;
         end
         S_ADDR: begin
            ld_sr  = {addr_r << {3'd4 - n_addr, 3'b000}, 32'd0};
            ld_cnt = is_quad ? {3'd0, n_addr, 1'b0} : {1'b0, n_addr, 3'b000};
            ld_oe  = is_quad ? 4'hF : 4'h1;
         end
         S_DUMMY: ld_cnt = {3'd0, n_dummy};
         S_DATA: begin
            ld_cnt = is_quad ? {2'd0, n_data, 1'b0} : {n_data, 3'b000};
            if (is_write) begin
               ld_sr = wdata_r << {4'd8 - n_data, 3'b000};
               ld_oe = is_quad ? 4'hF : 4'h1;
            end else begin
               ld_oe = is_quad ? 4'h0 : 4'h1;
            end
         end
         default: ;
      endcase
      ld_wide = is_quad && (nxt != S_OPCODE);
      ld_o    = ld_wide ? ld_sr[63:60] : {3'b000, ld_sr[63]};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         sr         <= '0;
         opcode     <= '0;
         n_addr     <= '0;
         n_dummy    <= '0;
         n_data     <= '0;
         is_write   <= 1'b0;
         is_quad    <= 1'b0;
         addr_r     <= '0;
         wdata_r    <= '0;
         qspi_rdata <= '0;
         qspi_idle  <= 1'b1;
         spi_sck    <= 1'b0;
         spi_cs_n   <= '1;
         dq_o       <= '0;
         dq_oe      <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
         if (state != S_IDLE) div_cnt <= tick ? DIV_LOAD : div_cnt - 8'd1;
         case (state)
            S_IDLE: if (qspi_start) begin
               opcode     <= qspi_cmd[7:0];
               n_addr     <= cmd_na;
               n_dummy    <= qspi_cmd[14:11];
               n_data     <= cmd_nb;
               is_write   <= qspi_cmd[19];
               is_quad    <= qspi_cmd[20];
               addr_r     <= qspi_addr;
               wdata_r    <= qspi_wdata;
               qspi_rdata <= '0;
               qspi_idle  <= 1'b0;
               spi_cs_n   <= ~qspi_bankmap[NB-1:0];
               div_cnt    <= DIV_LOAD;
               state      <= S_CS_SETUP;
            end
            S_CS_SETUP, S_OPCODE, S_ADDR, S_DUMMY, S_DATA: if (tick) begin
               if (state != S_CS_SETUP && !spi_sck) begin
                  // Rising SCK: the flash has had a full low half-period to drive DQ.
                  spi_sck <= 1'b1;
                  if (state == S_DATA && !is_write)
                     qspi_rdata <= is_quad ? {qspi_rdata[59:0], dq_i}
                                           : {qspi_rdata[62:0], dq_i[1]};
               end else begin
                  spi_sck <= 1'b0;
                  if (state == S_CS_SETUP || bit_cnt == 7'd1) begin
                     state   <= nxt;
                     sr      <= ld_sr;
                     bit_cnt <= ld_cnt;
                     dq_o    <= ld_o;
                     dq_oe   <= ld_oe;
                  end else begin
                     sr      <= sr_sh;
                     bit_cnt <= bit_cnt - 7'd1;
                     dq_o    <= sh_o;
                  end
               end
            end
            S_CS_HOLD: if (tick) begin
               spi_cs_n <= '1;
               state    <= S_CS_GAP;
            end
            S_CS_GAP: if (tick) begin
               qspi_idle <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_qspi_engine.sv
// Directed bench for qspi_engine: three instances (CLK_DIV 2, 1, 5) with a
// behavioural flash that answers reads and records every SCK-rise sample.
module tb_qspi_engine;
   typedef struct {
      logic [31:0] cmd;
      logic [31:0] bank;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [63:0] resp;
      logic [63:0] exp_rdata;
      logic [63:0] exp_addr;
      logic [63:0] exp_wd;
      int          exp_sck;
      logic [1:0]  exp_cs;
      logic [3:0]  exp_doe;
   } vec_t;

   localparam int NV = 7;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] qspi_cmd = '0, qspi_bankmap = '0, qspi_addr = '0;
   logic [63:0] qspi_wdata = '0;
   logic        start_w [3];

   wire [63:0] rdata_w [3];
   wire        idle_w  [3];
   wire        sck_w   [3];
   wire [1:0]  cs_w    [3];
   wire [3:0]  dqo_w   [3];
   wire [3:0]  dqoe_w  [3];
   wire [3:0]  dqi_w   [3];
   wire [31:0] n_w     [3];
   wire [31:0] per_w   [3];

   int          cyc = 0;
   int          base [3];
   logic [63:0] m_resp = '0;
   int          m_nb = 0, m_pre = 0;
   bit          m_quad = 1'b0;
   int          n_vec = 0, n_err = 0;
   vec_t        tbl [NV];

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // Flash response for rise index j of the current transaction.
   function automatic logic [3:0] model_dq(int j, logic [63:0] resp, int nb, bit quad, int pre);
      int i;
      logic [63:0] t;
      i = j - pre;
      model_dq = 4'b0000;
      if (i >= 0) begin
         if (quad && i < 2 * nb) begin
            t = resp >> (8 * nb - 4 * (i + 1));
            model_dq = t[3:0];
         end else if (!quad && i < 8 * nb) begin
            t = resp >> (8 * nb - 1 - i);
            model_dq = {2'b00, t[0], 1'b0};
         end
      end
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int DIV_K = (k == 0) ? 2 : (k == 1) ? 1 : 5;
      int         n = 0;
      int         last = 0;
      int         per = 0;
      logic [3:0] cap_o  [4096];
      logic [3:0] cap_oe [4096];
      logic [1:0] cap_cs [4096];

      always @(posedge sck_w[k]) begin
         cap_o[n % 4096]  = dqo_w[k];
         cap_oe[n % 4096] = dqoe_w[k];
         cap_cs[n % 4096] = cs_w[k];
         per  = cyc - last;
         last = cyc;
         n    = n + 1;
      end

      assign n_w[k]   = 32'(n);
      assign per_w[k] = 32'(per);
      assign dqi_w[k] = model_dq(n - base[k], m_resp, m_nb, m_quad, m_pre);

      qspi_engine #(.CLK_DIV(DIV_K), .NB(2)) u_dut (
         .clk          (clk),
         .resetn       (resetn),
         .qspi_cmd     (qspi_cmd),
         .qspi_bankmap (qspi_bankmap),
         .qspi_addr    (qspi_addr),
         .qspi_wdata   (qspi_wdata),
         .qspi_start   (start_w[k]),
         .qspi_rdata   (rdata_w[k]),
         .qspi_idle    (idle_w[k]),
         .spi_sck      (sck_w[k]),
         .spi_cs_n     (cs_w[k]),
         .dq_o         (dqo_w[k]),
         .dq_oe        (dqoe_w[k]),
         .dq_i         (dqi_w[k])
      );
   end

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Serial stream of instance 0 rebuilt from captured rise samples.
   function automatic logic [63:0] grab(int first, int cycles, bit quad);
      logic [63:0] v;
      logic [3:0]  s;
      v = '0;
      for (int i = 0; i < cycles; i++) begin
         s = g_dut[0].cap_o[(first + i) % 4096];
         v = quad ? {v[59:0], s} : {v[62:0], s[0]};
      end
      return v;
   endfunction

   function automatic int clamp_na(logic [31:0] cmd);
      return (cmd[10:8] > 3'd4) ? 4 : int'(cmd[10:8]);
   endfunction

   function automatic int clamp_nb(logic [31:0] cmd);
      return (cmd[18:15] > 4'd8) ? 8 : int'(cmd[18:15]);
   endfunction

   // Called at a negedge; start is seen at the following posedge.
   task automatic launch(int k, logic [31:0] cmd, logic [31:0] bank, logic [31:0] addr,
                         logic [63:0] wdata, logic [63:0] resp);
      int na;
      na           = clamp_na(cmd);
      m_quad       = cmd[20];
      m_resp       = resp;
      m_nb         = cmd[19] ? 0 : clamp_nb(cmd);
      m_pre        = 8 + (cmd[20] ? 2 * na : 8 * na) + int'(cmd[14:11]);
      base[k]      = int'(n_w[k]);
      qspi_cmd     = cmd;
      qspi_bankmap = bank;
      qspi_addr    = addr;
      qspi_wdata   = wdata;
      start_w[k]   = 1'b1;
      @(negedge clk);
      start_w[k]   = 1'b0;
      check($sformatf("busy_after_start[%0d]", k), {63'd0, idle_w[k]}, 64'd0);
   endtask

   task automatic wait_idle(int k);
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 4000 && !ok; t++) begin
         @(negedge clk);
         ok = idle_w[k];
      end
      check($sformatf("idle_return[%0d]", k), {63'd0, ok}, 64'd1);
   endtask

   initial begin
      int  b, na, nd, nb, ac, dc, busy_base;
      bit  q, hit;
      vec_t v;

      for (int k = 0; k < 3; k++) begin
         start_w[k] = 1'b0;
         base[k]    = 0;
      end

      //           cmd            bank           addr            wdata                   resp                    exp_rdata               exp_addr         exp_wd                  sck  cs     doe
      tbl[0] = '{32'h0000_809F, 32'h1,         32'h0,          64'h0,                  64'h20,                 64'h20,                 64'h0,           64'h0,                  16,  2'b10, 4'h1};
      tbl[1] = '{32'h0012_5C6B, 32'h2,         32'h0012_3456,  64'h0,                  64'hDEAD_BEEF,          64'hDEAD_BEEF,          64'h0012_3456,   64'h0,                  35,  2'b01, 4'h0};
      tbl[2] = '{32'h0008_8302, 32'h1,         32'h0000_0100,  64'hA5,                 64'h0,                  64'h0,                  64'h0000_0100,   64'hA5,                 40,  2'b10, 4'h1};
      tbl[3] = '{32'h001C_0438, 32'h3,         32'hCAFE_F00D,  64'h0123_4567_89AB_CDEF, 64'h0,                 64'h0,                  64'hCAFE_F00D,   64'h0123_4567_89AB_CDEF, 32, 2'b00, 4'hF};
      tbl[4] = '{32'h0007_C70B, 32'h1,         32'h89AB_CDEF,  64'h0,                  64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788, 64'h89AB_CDEF, 64'h0,                  112, 2'b10, 4'h1};
      tbl[5] = '{32'h0000_409F, 32'hFFFF_FFFC, 32'h0,          64'h0,                  64'hFF,                 64'h0,                  64'h0,           64'h0,                  16,  2'b11, 4'h0};
      tbl[6] = '{32'h0001_0303, 32'h2,         32'h00AB_CDEF,  64'h0,                  64'hBEEF,               64'hBEEF,               64'h00AB_CDEF,   64'h0,                  48,  2'b01, 4'h1};

      repeat (3) @(negedge clk);
      check("reset_pins", {56'd0, idle_w[0], sck_w[0], cs_w[0], dqo_w[0]},
            {56'd0, 1'b1, 1'b0, 2'b11, 4'h0});
      check("reset_oe", {60'd0, dqoe_w[0]}, 64'd0);
      check("reset_rdata", rdata_w[0], 64'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         v = tbl[i];
         launch(0, v.cmd, v.bank, v.addr, v.wdata, v.resp);
         wait_idle(0);
         b  = base[0];
         q  = v.cmd[20];
         na = clamp_na(v.cmd);
         nb = clamp_nb(v.cmd);
         nd = int'(v.cmd[14:11]);
         ac = q ? 2 * na : 8 * na;
         dc = q ? 2 * nb : 8 * nb;
         check($sformatf("rdata[%0d]", i), rdata_w[0], v.exp_rdata);
         check($sformatf("sck_count[%0d]", i), 64'(n_w[0] - 32'(b)), 64'(v.exp_sck));
         check($sformatf("opcode[%0d]", i), grab(b, 8, 1'b0), {56'd0, v.cmd[7:0]});
         check($sformatf("opcode_oe[%0d]", i), {60'd0, g_dut[0].cap_oe[b % 4096]}, 64'd1);
         check($sformatf("cs_n[%0d]", i), {62'd0, g_dut[0].cap_cs[b % 4096]}, {62'd0, v.exp_cs});
         if (na > 0)
            check($sformatf("addr[%0d]", i), grab(b + 8, ac, q), v.exp_addr);
         if (nd > 0)
            check($sformatf("dummy_oe[%0d]", i), {60'd0, g_dut[0].cap_oe[(b + 8 + ac) % 4096]}, 64'd0);
         if (nb > 0)
            check($sformatf("data_oe[%0d]", i), {60'd0, g_dut[0].cap_oe[(b + 8 + ac + nd) % 4096]},
                  {60'd0, v.exp_doe});
         if (nb > 0 && !v.cmd[19] && !q)
            check($sformatf("read_dq0[%0d]", i), {63'd0, g_dut[0].cap_o[(b + 8 + ac + nd) % 4096][0]}, 64'd0);
         if (v.cmd[19])
            check($sformatf("wdata[%0d]", i), grab(b + 8 + ac + nd, dc, q), v.exp_wd);
      end

      // Start while busy is ignored; start in the first idle cycle is taken.
      launch(0, 32'h0008_8302, 32'h1, 32'h0000_0100, 64'hA5, 64'h0);
      busy_base = base[0];
      repeat (20) @(negedge clk);
      qspi_cmd   = 32'h0000_809F;
      start_w[0] = 1'b1;
      @(negedge clk);
      start_w[0] = 1'b0;
      check("busy_ignored_idle", {63'd0, idle_w[0]}, 64'd0);
      wait_idle(0);
      check("busy_first_sck", 64'(n_w[0] - 32'(busy_base)), 64'd40);
      check("busy_first_opcode", grab(busy_base, 8, 1'b0), 64'h02);
      launch(0, 32'h0000_809F, 32'h1, 32'h0, 64'h0, 64'h20);
      wait_idle(0);
      check("back_to_back_rdata", rdata_w[0], 64'h20);
      check("back_to_back_total_sck", 64'(n_w[0] - 32'(busy_base)), 64'd56);
      repeat (3) @(negedge clk);
      check("no_duplicate_sck", 64'(n_w[0] - 32'(busy_base)), 64'd56);

      // Reset during the data phase of a quad read.
      launch(0, 32'h0012_5C6B, 32'h2, 32'h0012_3456, 64'h0, 64'hDEAD_BEEF);
      hit = 1'b0;
      for (int t = 0; t < 2000 && !hit; t++) begin
         @(negedge clk);
         hit = (int'(n_w[0]) - base[0]) >= m_pre + 3;
      end
      check("reach_data_phase", {63'd0, hit}, 64'd1);
      resetn = 1'b0;
      #1;
      check("abort_pins", {56'd0, idle_w[0], sck_w[0], cs_w[0], dqo_w[0]},
            {56'd0, 1'b1, 1'b0, 2'b11, 4'h0});
      check("abort_oe", {60'd0, dqoe_w[0]}, 64'd0);
      check("abort_rdata", rdata_w[0], 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      launch(0, 32'h0000_809F, 32'h1, 32'h0, 64'h0, 64'h20);
      wait_idle(0);
      check("after_abort_rdata", rdata_w[0], 64'h20);

      // Read ID at CLK_DIV 1 and 5.
      for (int k = 1; k < 3; k++) begin
         launch(k, 32'h0000_809F, 32'h1, 32'h0, 64'h0, 64'h20);
         wait_idle(k);
         check($sformatf("div_rdata[%0d]", k), rdata_w[k], 64'h20);
         check($sformatf("div_sck_count[%0d]", k), 64'(n_w[k] - 32'(base[k])), 64'd16);
         check($sformatf("div_period[%0d]", k), 64'(per_w[k]), (k == 1) ? 64'd2 : 64'd10);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
